// File: rtl/wunpk_pkg.sv
// Shared defaults, state encoding and byte-lane helper for the word_unpacker slice.
package wunpk_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int RATIO_DEF = 4;
  localparam int ASIZE_DEF = 1;
  localparam int IDXW      = $clog2(RATIO_DEF);

  // STREAM means at least one word (possibly partially sent) is buffered.
  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Map the running byte counter onto the physical lane of the head word.
  function automatic int unsigned byte_lane(input int unsigned idx,
                                            input int unsigned ratio,
                                            input bit          msb_first);
    return msb_first ? (ratio - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/wunpk_mem.sv
// Word buffer storage: synchronous write port, asynchronous read port, no reset.
module wunpk_mem #(
  parameter int WIDTH = 32,
  parameter int ASIZE = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**ASIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/word_unpacker.sv
// Word-to-byte downconverter: buffers packed words and streams them out one byte per cycle.
// Build option: define WUNPK_MSB_FIRST_EN to send the most significant byte of each word first.
module word_unpacker
  import wunpk_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int RATIO = RATIO_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [DSIZE*RATIO-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DSIZE-1:0]       out_data,
  input  logic                   out_ready,
  output logic                   wfull,
  output logic                   rempty,
  output logic [ASIZE:0]         level
);

  localparam int WW = DSIZE * RATIO;
  localparam int IW = $clog2(RATIO);

`ifdef WUNPK_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  logic [ASIZE:0] wptr, rptr;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  lane;
  logic [WW-1:0]  rd_word;
  state_t         state, state_nx;
  logic           push, xfer, last_byte, pop;

  // clr wins over any same-cycle transfer, so it also masks the memory write.
  assign push      = in_valid && in_ready && !clr;
  assign xfer      = out_valid && out_ready && !clr;
  assign last_byte = (idx == IW'(RATIO - 1));
  assign pop       = xfer && last_byte;

  assign wfull    = (wptr[ASIZE] != rptr[ASIZE]) &&
                    (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
  assign in_ready = !wfull;
  assign level    = wptr - rptr;

  wunpk_mem #(
    .WIDTH (WW),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr[ASIZE-1:0]),
    .wdata (in_data),
    .raddr (rptr[ASIZE-1:0]),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      idx  <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      idx  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (xfer) begin
        idx <= last_byte ? '0 : idx + 1'b1;
        if (last_byte) rptr <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // State mirrors pointer equality, so out_valid never depends on out_ready.
  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (push) state_nx = STREAM;
        STREAM:  if (pop && !push && level == {{ASIZE{1'b0}}, 1'b1}) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign rempty    = (state == IDLE);
  assign out_valid = (state == STREAM);

  assign lane     = IW'(byte_lane(32'(idx), RATIO, MSB_FIRST));
  assign out_data = rd_word[lane*DSIZE +: DSIZE];

endmodule

// File: doc/word_unpacker.md
# word_unpacker

Single-clock 32-to-8 width downconverter: the transmit-side counterpart of the byte-to-word async FIFO. It accepts packed words of RATIO bytes into a small word buffer and emits them one byte per cycle on a valid/ready stream. It sits between a word-wide producer, such as the FIFO read side or a file-driven bench source, and a byte-wide consumer.

## Interface
- DSIZE, 8, byte width in bits
- RATIO, 4, bytes per input word; power of 2, at least 2
- ASIZE, 1, log2 of the word-buffer depth (DEPTH = 2**ASIZE)
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush, active-high
- in_valid  in  1  input word valid
- in_data  in  DSIZE*RATIO  packed input word
- in_ready  out  1  buffer can accept a word
- out_valid  out  1  output byte valid
- out_data  out  DSIZE  output byte
- out_ready  in  1  consumer accepts the byte
- wfull  out  1  word buffer full
- rempty  out  1  word buffer empty
- level  out  ASIZE+1  number of buffered words, including the partially sent head word

## Operation
- **Buffer.** DEPTH-entry word memory.
  - Write and read pointers are ASIZE+1 bits wide; the extra bit is a wrap flag.
  - Empty: pointers equal.
  - Full: pointers differ only in the MSB.
- **Push.** Occurs when in_valid && in_ready. mem[wptr] <= in_data, then wptr++.
- **in_ready.** Equals !wfull, derived from registered pointers.
  - There is no bypass: when the buffer is full, a same-cycle pop does not allow a push.
- **Byte index.** idx is a log2(RATIO)-bit counter over the head word. out_data is byte idx of mem[rptr], with byte 0 = bits [DSIZE-1:0].
- **out_valid.** Equals !rempty.
- **Byte transfer.** Occurs when out_valid && out_ready.
  - If idx == RATIO-1: idx <= 0, rptr++ (pop).
  - Otherwise: idx++.
- **State machine** (2 states, encoded by rempty):
  - IDLE (empty) goes to STREAM on push.
  - STREAM goes to IDLE on a pop of the last word with no same-cycle push.
- **Simultaneous push and pop.** Both take effect; level is unchanged.
- **clr.** Sets wptr, rptr and idx to 0 on the next edge. It overrides a same-cycle push or pop. Memory contents are not cleared.
- **Stall.** With out_valid high and out_ready low, out_data and idx hold.
- **Reset values.** in_ready=1, out_valid=0, wfull=0, rempty=1, level=0. out_data is don't-care until out_valid.
- **Reset mid-stream.** Any partially sent word is discarded, with no further bytes emitted.

## Timing
- Word-to-first-byte latency: a push on edge N gives out_valid=1 after edge N, so the byte can transfer at edge N+1.
- out_data is a combinational mux of registered memory and idx; there is no output register.
- Sustained throughput is 1 byte/cycle. The producer needs 1 word per RATIO cycles; with DEPTH >= 2 there are no bubbles.
- wfull, rempty and level update on the edge after the push or pop that changes them.
- out_valid must not depend combinationally on out_ready, and in_ready must not depend combinationally on in_valid.

## Configuration
- Macro: WUNPK_MSB_FIRST_EN.
- Defined: byte order is reversed; the first byte is bits [DSIZE*RATIO-1 : DSIZE*(RATIO-1)].
- Undefined: the LSB byte is sent first, as described above.
- Handshake timing and all counters are identical in both builds.

## Structure
- Package wunpk_pkg holds:
  - default DSIZE, RATIO and ASIZE;
  - localparam IDXW = $clog2(RATIO);
  - a function for byte select with an MSB-first flag.
- Sub-module wunpk_mem is the DEPTH x (DSIZE*RATIO) storage, with a synchronous write port and an asynchronous read port.
- Pointers, the idx counter, flags and the byte mux live in word_unpacker.

## Test plan
- **Reset.** Hold rstn=0 for 3 cycles, then release → in_ready=1, out_valid=0, rempty=1, level=0.
- **Single word.** Push 32'h44332211 with out_ready=1 → out_data sequence 11,22,33,44 on 4 consecutive cycles, then rempty=1.
  - With WUNPK_MSB_FIRST_EN defined → 44,33,22,11.
- **Full and backpressure.** out_ready=0, push 32'hA0A1A2A3 and 32'hB0B1B2B3 → wfull=1, in_ready=0, level=2. A third word presented is not accepted. Then raise out_ready → 8 bytes emitted in order; the third word is accepted on the cycle after the first pop.
- **Stall mid-word.** Drop out_ready after byte 22 for 5 cycles → out_data holds 33 and idx does not advance.
- **Simultaneous push and pop.** At level=1 with idx=3, push a word on the same cycle the last byte transfers → level stays 1, and the next byte is byte 0 of the new word.
- **Flush and reset mid-word.** clr=1 after 2 bytes → next cycle rempty=1 and level=0. Separately, drop rstn asynchronously mid-word → outputs go to reset values immediately, with no residual bytes after release.
